// File: rtl/wave_capture_analyzer.sv
// wave_capture_analyzer
//   Measures each cycle of an 8-bit unsigned sampled waveform. Cycles are
//   delimited by rising crossings of a hysteresis comparator centred on MID.
//   One result (period in samples, max, min) is reported per cycle.
// Ports
//   clk_50MHz     in   system clock, rising edge
//   reset         in   asynchronous, active-high
//   enable        in   1 = analyse, 0 = idle (results and timeout hold)
//   sample_in     in   [7:0] unsigned sample, qualified by sample_valid
//   sample_valid  in   sample_in accepted on the clock edge while high
//   period_out    out  [PCNT_W-1:0] samples in last measured cycle
//   vmax_out      out  [7:0] max sample in last measured cycle
//   vmin_out      out  [7:0] min sample in last measured cycle
//   result_valid  out  one-clock pulse when period/vmax/vmin update
//   locked        out  at least one result since last SYNC entry
//   timeout       out  sticky: no rising crossing within MAX_PERIOD samples
module wave_capture_analyzer #(
    parameter int unsigned MID    = 128,
    parameter int unsigned HYST   = 8,
    parameter int unsigned PCNT_W = 10
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    input  logic              enable,
    input  logic [7:0]        sample_in,
    input  logic              sample_valid,
    output logic [PCNT_W-1:0] period_out,
    output logic [7:0]        vmax_out,
    output logic [7:0]        vmin_out,
    output logic              result_valid,
    output logic              locked,
    output logic              timeout
);

    localparam int unsigned         SAMPLE_W   = 8;
    localparam logic [SAMPLE_W-1:0] TH_HIGH    = SAMPLE_W'(MID + HYST);
    localparam logic [SAMPLE_W-1:0] TH_LOW     = SAMPLE_W'(MID - HYST);
    localparam logic [PCNT_W-1:0]   MAX_PERIOD = {PCNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    state_t                r_state,     w_state_next;
    logic                  r_comp_high, w_comp_high_next;
    logic [PCNT_W-1:0]     r_cnt,       w_cnt_next;
    logic [SAMPLE_W-1:0]   r_run_max,   w_run_max_next;
    logic [SAMPLE_W-1:0]   r_run_min,   w_run_min_next;
    logic [PCNT_W-1:0]     r_period,    w_period_next;
    logic [SAMPLE_W-1:0]   r_vmax,      w_vmax_next;
    logic [SAMPLE_W-1:0]   r_vmin,      w_vmin_next;
    logic                  r_result_valid, w_result_valid_next;
    logic                  r_locked,    w_locked_next;
    logic                  r_timeout,   w_timeout_next;

    logic                  w_rise;
    logic [PCNT_W-1:0]     w_cnt_inc;

    // A rise is a LOW->HIGH comparator transition on an accepted sample.
    assign w_rise    = enable && sample_valid && !r_comp_high && (sample_in >= TH_HIGH);
    // cnt stays below MAX_PERIOD, so the increment cannot wrap.
    assign w_cnt_inc = r_cnt + PCNT_W'(1);

    // State register and all registered outputs.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_comp_high    <= 1'b0;
            r_cnt          <= '0;
            r_run_max      <= '0;
            r_run_min      <= '0;
            r_period       <= '0;
            r_vmax         <= '0;
            r_vmin         <= '0;
            r_result_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_comp_high    <= w_comp_high_next;
            r_cnt          <= w_cnt_next;
            r_run_max      <= w_run_max_next;
            r_run_min      <= w_run_min_next;
            r_period       <= w_period_next;
            r_vmax         <= w_vmax_next;
            r_vmin         <= w_vmin_next;
            r_result_valid <= w_result_valid_next;
            r_locked       <= w_locked_next;
            r_timeout      <= w_timeout_next;
        end
    end

    // Next-state, comparator and measurement logic.
    always_comb begin
        w_state_next        = r_state;
        w_comp_high_next    = r_comp_high;
        w_cnt_next          = r_cnt;
        w_run_max_next      = r_run_max;
        w_run_min_next      = r_run_min;
        w_period_next       = r_period;
        w_vmax_next         = r_vmax;
        w_vmin_next         = r_vmin;
        w_result_valid_next = 1'b0;
        w_locked_next       = r_locked;
        w_timeout_next      = r_timeout;

        if (!enable) begin
            // Results and timeout hold; the comparator restarts from LOW.
            w_state_next     = ST_IDLE;
            w_locked_next    = 1'b0;
            w_comp_high_next = 1'b0;
        end else if (sample_valid) begin
            if (sample_in >= TH_HIGH) begin
                w_comp_high_next = 1'b1;
            end else if (sample_in <= TH_LOW) begin
                w_comp_high_next = 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    w_state_next   = ST_SYNC;
                    w_timeout_next = 1'b0;
                end
                ST_SYNC: begin
                    if (w_rise) begin
                        w_cnt_next     = '0;
                        w_run_max_next = sample_in;
                        w_run_min_next = sample_in;
                        w_state_next   = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        // Rise sample opens the next cycle; it is not in this result.
                        w_period_next       = w_cnt_inc;
                        w_vmax_next         = r_run_max;
                        w_vmin_next         = r_run_min;
                        w_result_valid_next = 1'b1;
                        w_locked_next       = 1'b1;
                        w_timeout_next      = 1'b0;
                        w_cnt_next          = '0;
                        w_run_max_next      = sample_in;
                        w_run_min_next      = sample_in;
                    end else if (w_cnt_inc == MAX_PERIOD) begin
                        w_timeout_next = 1'b1;
                        w_locked_next  = 1'b0;
                        w_state_next   = ST_SYNC;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                        if (sample_in > r_run_max) begin
                            w_run_max_next = sample_in;
                        end
                        if (sample_in < r_run_min) begin
                            w_run_min_next = sample_in;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign period_out   = r_period;
    assign vmax_out     = r_vmax;
    assign vmin_out     = r_vmin;
    assign result_valid = r_result_valid;
    assign locked       = r_locked;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_wave_capture_analyzer.sv
// tb_wave_capture_analyzer
//   Drives directed waveforms (sine, square, sawtooth, half-rate sine,
//   flat line, long-period pulses) followed by randomized traffic into
//   wave_capture_analyzer, and compares every cycle against a cycle-level
//   model that keeps the samples of the current waveform cycle in a queue.
module tb_wave_capture_analyzer;

    localparam int unsigned PCNT_W = 10;
    localparam int MID   = 128;
    localparam int HYST  = 8;
    localparam int MAXP  = 1023;

    logic              clk_50MHz;
    logic              reset;
    logic              enable;
    logic [7:0]        sample_in;
    logic              sample_valid;
    logic [PCNT_W-1:0] period_out;
    logic [7:0]        vmax_out;
    logic [7:0]        vmin_out;
    logic              result_valid;
    logic              locked;
    logic              timeout;

    wave_capture_analyzer #(
        .MID    (128),
        .HYST   (8),
        .PCNT_W (PCNT_W)
    ) dut (
        .clk_50MHz    (clk_50MHz),
        .reset        (reset),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .period_out   (period_out),
        .vmax_out     (vmax_out),
        .vmin_out     (vmin_out),
        .result_valid (result_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    initial clk_50MHz = 1'b0;
    always #10 clk_50MHz = ~clk_50MHz;

    int checks   = 0;
    int failures = 0;

    // Model state: mode 0=idle 1=waiting for first rise 2=measuring.
    int m_mode      = 0;
    bit m_comp_high = 0;
    int m_cycle[$];
    int m_period    = 0;
    int m_vmax      = 0;
    int m_vmin      = 0;
    bit m_rv        = 0;
    bit m_locked    = 0;
    bit m_timeout   = 0;

    int cyc     = 0;
    int rv_last = 0;
    int rv_gap  = 0;

    int sine_lut[32];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit rise;
        int hi;
        int lo;
        if (reset) begin
            m_mode = 0; m_comp_high = 0; m_cycle.delete();
            m_period = 0; m_vmax = 0; m_vmin = 0;
            m_rv = 0; m_locked = 0; m_timeout = 0;
            return;
        end
        m_rv = 0;
        if (!enable) begin
            m_mode = 0; m_locked = 0; m_comp_high = 0;
            return;
        end
        if (!sample_valid) return;
        rise = !m_comp_high && (int'(sample_in) >= MID + HYST);
        if (int'(sample_in) >= MID + HYST) m_comp_high = 1;
        else if (int'(sample_in) <= MID - HYST) m_comp_high = 0;
        case (m_mode)
            0: begin m_mode = 1; m_timeout = 0; end
            1: if (rise) begin
                   m_cycle.delete();
                   m_cycle.push_back(int'(sample_in));
                   m_mode = 2;
               end
            default: begin
                if (rise) begin
                    hi = 0; lo = 255;
                    foreach (m_cycle[i]) begin
                        if (m_cycle[i] > hi) hi = m_cycle[i];
                        if (m_cycle[i] < lo) lo = m_cycle[i];
                    end
                    m_period = m_cycle.size();
                    m_vmax = hi; m_vmin = lo;
                    m_rv = 1; m_locked = 1; m_timeout = 0;
                    m_cycle.delete();
                    m_cycle.push_back(int'(sample_in));
                end else if (m_cycle.size() == MAXP) begin
                    m_timeout = 1; m_locked = 0; m_mode = 1;
                end else begin
                    m_cycle.push_back(int'(sample_in));
                end
            end
        endcase
    endtask

    // Per-cycle compare against the model, sampled 1 time unit after the edge.
    always begin
        @(posedge clk_50MHz);
        model_step();
        cyc++;
        #1;
        checks++;
        if ({period_out, vmax_out, vmin_out, result_valid, locked, timeout} !==
            {PCNT_W'(m_period), 8'(m_vmax), 8'(m_vmin), m_rv, m_locked, m_timeout}) begin
            failures++;
            $display("FAIL cycle %0d: got period=%0d vmax=%0d vmin=%0d rv=%b locked=%b timeout=%b expected period=%0d vmax=%0d vmin=%0d rv=%b locked=%b timeout=%b",
                     cyc, period_out, vmax_out, vmin_out, result_valid, locked, timeout,
                     m_period, m_vmax, m_vmin, m_rv, m_locked, m_timeout);
        end
        if (result_valid === 1'b1) begin
            rv_gap  = cyc - rv_last;
            rv_last = cyc;
        end
    end

    task automatic put(input int v, input bit vld);
        @(negedge clk_50MHz);
        sample_in    = 8'(v);
        sample_valid = vld;
    endtask

    function automatic int square_wave(input int k);
        return ((k % 32) < 16) ? 255 : 0;
    endfunction

    function automatic int saw_wave(input int k);
        return ((k % 32) * 247) / 31;
    endfunction

    initial begin
        int v;
        int p;
        int hi;
        int lo;
        int n;

        for (int k = 0; k < 32; k++) begin
            v = int'(127.5 + 127.5 * $sin(2.0 * 3.14159265358979 * real'(k) / 32.0));
            if (v > 255) v = 255;
            if (v < 0) v = 0;
            sine_lut[k] = v;
        end

        reset = 1'b1; enable = 1'b0; sample_in = 8'd0; sample_valid = 1'b0;
        repeat (3) @(negedge clk_50MHz);
        chk("reset_period", int'(period_out), 0);
        chk("reset_vmax", int'(vmax_out), 0);
        chk("reset_vmin", int'(vmin_out), 0);
        chk("reset_rv", int'(result_valid), 0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_timeout", int'(timeout), 0);
        reset = 1'b0; enable = 1'b1;

        // Sine, one sample per clock.
        for (int k = 0; k < 32 * 11; k++) put(sine_lut[k % 32], 1'b1);
        put(0, 1'b0);
        chk("sine_period", int'(period_out), 32);
        chk("sine_vmax", int'(vmax_out), 255);
        chk("sine_vmin", int'(vmin_out), 0);
        chk("sine_locked", int'(locked), 1);
        chk("sine_rv_gap", rv_gap, 32);

        // Drop enable mid-cycle: lock lost, results hold.
        for (int k = 0; k < 10; k++) put(sine_lut[k], 1'b1);
        enable = 1'b0;
        put(0, 1'b0); put(0, 1'b0);
        chk("endrop_locked", int'(locked), 0);
        chk("endrop_period", int'(period_out), 32);
        enable = 1'b1;

        for (int k = 0; k < 32 * 6; k++) put(square_wave(k), 1'b1);
        put(0, 1'b0);
        chk("square_period", int'(period_out), 32);
        chk("square_vmax", int'(vmax_out), 255);
        chk("square_vmin", int'(vmin_out), 0);

        for (int k = 0; k < 32 * 6; k++) put(saw_wave(k), 1'b1);
        put(0, 1'b0);
        chk("saw_period", int'(period_out), 32);
        chk("saw_vmax", int'(vmax_out), 247);
        chk("saw_vmin", int'(vmin_out), 0);

        // Sine with a valid sample every other clock.
        for (int k = 0; k < 32 * 8; k++) begin
            put(sine_lut[k % 32], 1'b1);
            put(int'($urandom_range(0, 255)), 1'b0);
        end
        chk("half_period", int'(period_out), 32);
        chk("half_rv_gap", rv_gap, 64);

        // Reset mid-cycle.
        for (int k = 0; k < 12; k++) put(sine_lut[k], 1'b1);
        reset = 1'b1;
        put(0, 1'b0); put(0, 1'b0);
        chk("midrst_period", int'(period_out), 0);
        chk("midrst_locked", int'(locked), 0);
        reset = 1'b0;
        for (int k = 12; k < 12 + 32 * 4; k++) put(sine_lut[k % 32], 1'b1);

        // Flat line after lock: timeout, lock lost, last result holds.
        for (int k = 0; k < 1100; k++) put(128, 1'b1);
        put(0, 1'b0);
        chk("flat_timeout", int'(timeout), 1);
        chk("flat_locked", int'(locked), 0);
        chk("flat_period", int'(period_out), 32);

        // Longest measurable period, then one sample longer.
        for (int k = 0; k < 10; k++) put(100, 1'b1);
        put(200, 1'b1);
        for (int k = 0; k < 1022; k++) put(100, 1'b1);
        put(200, 1'b1);
        put(0, 1'b0);
        chk("maxp_period", int'(period_out), 1023);
        chk("maxp_vmax", int'(vmax_out), 200);
        chk("maxp_vmin", int'(vmin_out), 100);
        chk("maxp_timeout", int'(timeout), 0);
        for (int k = 0; k < 1023; k++) put(100, 1'b1);
        put(0, 1'b0);
        chk("overp_timeout", int'(timeout), 1);
        chk("overp_locked", int'(locked), 0);

        // Randomized pulse trains with noise, gaps, enable drops and resets.
        for (int it = 0; it < 40; it++) begin
            p  = int'($urandom_range(4, 80));
            hi = int'($urandom_range(136, 255));
            lo = int'($urandom_range(0, 120));
            n  = p * int'($urandom_range(2, 6));
            for (int t = 0; t < n; t++) begin
                v = ((t % p) < (p / 2)) ? hi : lo;
                if ($urandom_range(0, 7) == 0) v = int'($urandom_range(121, 135));
                if ($urandom_range(0, 15) == 0) v = int'($urandom_range(0, 255));
                put(v, ($urandom_range(0, 3) != 0));
                enable = ($urandom_range(0, 299) != 0);
                reset  = ($urandom_range(0, 999) == 0);
            end
        end
        reset = 1'b0; enable = 1'b1;
        put(0, 1'b0); put(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
